// File: rtl/axis_pack_output_bp.sv
// Byte-stream repacker: variable-count input beats are packed into fixed-width
// AXI-Stream words through a byte accumulator, with output backpressure.
module axis_pack_output_bp #(
    parameter int N_BYTES_IN  = 4,
    parameter int N_BYTES_OUT = 4,
    localparam int ACC = N_BYTES_IN + N_BYTES_OUT - 1,
    localparam int CW  = $clog2(ACC + 1),
    localparam int SCW = $clog2(N_BYTES_IN + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [8*N_BYTES_IN-1:0]  s_bytes,
    input  logic [SCW-1:0]           s_cnt,
    input  logic                     s_last,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [8*N_BYTES_OUT-1:0] m_tdata,
    output logic [N_BYTES_OUT-1:0]   m_tkeep,
    output logic                     m_tlast,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [CW-1:0]            occ
);

    localparam logic [CW-1:0] OUT_W = CW'(N_BYTES_OUT);

    logic [8*ACC-1:0]         acc_q, acc_d;
    logic [CW-1:0]            fill_q, fill_d, pop_cnt, fill_rem;
    logic                     flush_q, flush_d;
    logic                     out_free, pop, pop_last, accept;
    logic [8*N_BYTES_OUT-1:0] word;
    logic [N_BYTES_OUT-1:0]   keep;

    always_comb begin
        out_free = !m_tvalid || m_tready;
        pop      = out_free && (fill_q >= OUT_W || (flush_q && fill_q != '0));
        pop_last = flush_q && (fill_q <= OUT_W);
        pop_cnt  = '0;
        if (pop)
            pop_cnt = (fill_q >= OUT_W) ? OUT_W : fill_q;
        fill_rem = fill_q - pop_cnt;
        s_ready  = !rst && !flush_q && (int'(fill_rem) + N_BYTES_IN <= ACC);
        accept   = s_valid && s_ready;
    end

    // Bytes above fill are kept at zero, but the mask makes unused lanes explicit.
    always_comb begin
        keep = '0;
        word = '0;
        for (int i = 0; i < N_BYTES_OUT; i++) begin
            keep[i] = int'(fill_q) > i;
            word[8*i +: 8] = keep[i] ? acc_q[8*i +: 8] : 8'h00;
        end
    end

    // Shift out the popped bytes, then append the new beat at the post-pop fill.
    always_comb begin
        acc_d = '0;
        for (int i = 0; i < ACC; i++) begin
            if (i + int'(pop_cnt) < ACC)
                acc_d[8*i +: 8] = acc_q[8*(i + int'(pop_cnt)) +: 8];
        end
        for (int j = 0; j < N_BYTES_IN; j++) begin
            if (accept && j < int'(s_cnt) && int'(fill_rem) + j < ACC)
                acc_d[8*(int'(fill_rem) + j) +: 8] = s_bytes[8*j +: 8];
        end
        fill_d = fill_rem + (accept ? CW'(s_cnt) : '0);
    end

    always_comb begin
        flush_d = flush_q;
        if (pop && pop_last)
            flush_d = 1'b0;
        else if (flush_q && fill_q == '0)
            flush_d = 1'b0;
        if (accept && s_last)
            flush_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            fill_q   <= '0;
            flush_q  <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tvalid <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            flush_q <= flush_d;
            if (pop) begin
                m_tdata  <= word;
                m_tkeep  <= keep;
                m_tlast  <= pop_last;
                m_tvalid <= 1'b1;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end

    assign occ = fill_q;

endmodule
